memmu_sr_angle_reader: RTL and testbench
========================================

// Module: memmu_sr_angle_reader
// PURPOSE
//  Reverse path of the MemMU spherical-representation addressing: walks a range of representation
//  addresses, fetches each stored 4-bit correction from the representation memory and rebuilds the
//  sensor angle (hundredths of a degree) as addr*RESOLUTION + correction. Sits between the MemMU
//  representation memory read port and downstream consumers (extension units, point-cloud output).
// PARAMETERS
//  NUMBER_OF_ADDR_BITS  14   address width; 2**N addresses span the FOV
//  FOV                  360  representation field of view, degrees
//  (derived) RESOLUTION = (FOV*100)/2**N + 1 ; MAXFOV = FOV*100 - 1   (integer arithmetic)
// PORTS
//  i_SYSTEM_clk      in   1   clock, all state on rising edge
//  i_SYSTEM_rst      in   1   reset, asynchronous, active-low
//  i_start           in   1   start-scan pulse, sampled only in IDLE
//  i_abort           in   1   abandon scan, return to IDLE
//  i_first_addr      in   N   first address of scan, sampled with i_start
//  i_last_addr       in   N   last address of scan (inclusive), sampled with i_start
//  o_rd_en           out  1   memory read strobe, one cycle per address
//  o_rd_addr         out  N   memory read address
//  i_rd_correction   in   4   correction data, valid the cycle after o_rd_en
//  o_valid           out  1   output sample valid
//  i_ready           in   1   downstream accepts sample
//  o_angle           out  16  reconstructed angle, 0..MAXFOV
//  o_addr            out  N   address the sample belongs to
//  o_busy            out  1   high in any state other than IDLE
//  o_done            out  1   one-cycle pulse after last sample of a scan is accepted
// BEHAVIOUR
//  Reset (async assert, sync deassert by flops): state=IDLE; every output 0; internal addr/last regs 0.
//  FSM: IDLE -> RD -> CAP -> OUT -> (RD | DONE) ; DONE -> IDLE.
//   IDLE: i_start=1 & i_abort=0 -> latch first/last, cur_addr=first, go RD. Else stay.
//   RD  : o_rd_en=1, o_rd_addr=cur_addr for exactly this cycle; go CAP.
//   CAP : sample i_rd_correction at end of cycle, register o_angle/o_addr, go OUT.
//   OUT : o_valid=1; o_angle/o_addr held stable until o_valid&i_ready at a rising edge.
//         On transfer: cur_addr==last -> DONE, else cur_addr=cur_addr+1 (mod 2**N) -> RD.
//   DONE: o_done=1 for this single cycle, o_valid=0; go IDLE.
//  Latency: i_start sampled at edge k -> o_rd_en high cycle k+1 -> o_valid high from cycle k+3.
//  Throughput with i_ready held high: one sample per 3 cycles. o_valid never drops without transfer
//   except on i_abort or reset.
//  Arithmetic: 32-bit product cur_addr*RESOLUTION + correction; result > MAXFOV saturates to MAXFOV;
//   o_angle = low 16 bits after saturation.
//  Range: first==last -> exactly one sample. first>last -> scan wraps 2**N-1 -> 0, continues to last.
//   Full-circle scan: first=0, last=2**N-1.
//  i_start outside IDLE ignored (no restart, first/last unchanged). i_start and i_abort together in
//   IDLE -> stay IDLE.
//  i_abort in any non-IDLE state -> IDLE next cycle; o_valid, o_rd_en low next cycle; no o_done pulse;
//   a sample pending in OUT is discarded even if i_ready=1 in the same cycle.
//  Reset mid-scan: immediate return to reset values, no o_done.
//  o_rd_en only asserted in RD; no read issued while in OUT waiting on i_ready.
// TESTING (N=14, FOV=360 -> RESOLUTION=3, MAXFOV=35999)
//  1 Basic: first=0,last=3, memory corr {0,1,2,2}, ready=1 -> angles 0,4,8,11, addr 0..3, o_done once
//    one cycle after 4th transfer; o_valid first high 3 cycles after start edge.
//  2 Saturation: first=last=12000, corr=5 -> one sample o_angle=35999; addr=11999,corr=2 -> 35999;
//    addr=11000,corr=7 -> 33007.
//  3 Wrap: first=16382,last=1 -> o_rd_addr sequence 16382,16383,0,1; four samples then o_done.
//  4 Backpressure: hold i_ready=0 for 5 cycles in OUT -> o_valid=1, o_angle/o_addr stable, no o_rd_en;
//    release -> single transfer, next o_rd_en following cycle.
//  5 Abort: first=0,last=100, assert i_abort during 3rd sample's OUT with i_ready=1 -> sample not
//    counted, IDLE next cycle, o_busy=0, no o_done; i_start during scan ignored.
//  6 Reset mid-scan: drop i_SYSTEM_rst asynchronously in CAP -> all outputs 0 before next edge; new
//    start after release runs clean scan.

Source files
------------

// File: rtl/memmu_sr_angle_reader.sv
// ---------------------------------------------------------------------------
// memmu_sr_angle_reader
//
// Reverse path of the MemMU spherical-representation addressing. Walks an
// inclusive range of representation addresses (wrapping 2**N-1 -> 0 when
// first > last). For each address it reads the stored 4-bit correction and
// rebuilds the sensor angle in hundredths of a degree:
//     angle = min(addr*RESOLUTION + correction, MAXFOV)
//
// Ports
//   i_SYSTEM_clk     clock, all state on the rising edge
//   i_SYSTEM_rst     asynchronous active-low reset
//   i_start          start-scan pulse, only honoured in IDLE
//   i_abort          abandon the scan, back to IDLE next cycle, no o_done
//   i_first_addr     first scan address, captured with i_start
//   i_last_addr      last scan address (inclusive), captured with i_start
//   o_rd_en          memory read strobe, one cycle per address
//   o_rd_addr        memory read address, driven only while o_rd_en is high
//   i_rd_correction  correction data, valid the cycle after o_rd_en
//   o_valid          sample valid
//   i_ready          downstream accepts sample
//   o_angle          reconstructed angle, 0..MAXFOV
//   o_addr           address the sample belongs to
//   o_busy           high whenever the FSM is not in IDLE
//   o_done           one-cycle pulse after the last sample is accepted
//   o_dbg_state      current FSM state, for checkers and debug
//
// Handshake: a sample transfers on a rising edge where o_valid and i_ready
// are both high. Once o_valid rises, o_angle/o_addr stay stable and o_valid
// stays high until that transfer, unless i_abort or reset intervene.
// ---------------------------------------------------------------------------
module memmu_sr_angle_reader #(
    parameter int NUMBER_OF_ADDR_BITS = 14,
    parameter int FOV                 = 360
) (
    input  logic                           i_SYSTEM_clk,
    input  logic                           i_SYSTEM_rst,
    input  logic                           i_start,
    input  logic                           i_abort,
    input  logic [NUMBER_OF_ADDR_BITS-1:0] i_first_addr,
    input  logic [NUMBER_OF_ADDR_BITS-1:0] i_last_addr,
    output logic                           o_rd_en,
    output logic [NUMBER_OF_ADDR_BITS-1:0] o_rd_addr,
    input  logic [3:0]                     i_rd_correction,
    output logic                           o_valid,
    input  logic                           i_ready,
    output logic [15:0]                    o_angle,
    output logic [NUMBER_OF_ADDR_BITS-1:0] o_addr,
    output logic                           o_busy,
    output logic                           o_done,
    output logic [2:0]                     o_dbg_state
);

    localparam int N = NUMBER_OF_ADDR_BITS;

    // Integer arithmetic: the +1 rounds the step up so the top address still
    // lands at or beyond MAXFOV; saturation then clips it.
    localparam logic [31:0] LP_RESOLUTION = 32'((FOV * 100) / (2 ** N) + 1);
    localparam logic [31:0] LP_MAXFOV     = 32'(FOV * 100 - 1);
    localparam logic [15:0] LP_MAXFOV_16  = 16'(FOV * 100 - 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RD   = 3'd1,
        S_CAP  = 3'd2,
        S_OUT  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t         r_state;
    state_t         w_state_next;
    logic [N-1:0]   r_cur_addr;
    logic [N-1:0]   r_last_addr;
    logic [15:0]    r_angle;
    logic [N-1:0]   r_addr;

    logic           w_start_ok;
    logic           w_xfer;
    logic           w_at_last;
    logic [31:0]    w_sum;
    logic [15:0]    w_angle_sat;

    assign w_start_ok = i_start && !i_abort;
    // An abort in OUT discards the pending sample even with i_ready high.
    assign w_xfer     = (r_state == S_OUT) && i_ready && !i_abort;
    assign w_at_last  = (r_cur_addr == r_last_addr);

    assign w_sum       = (32'(r_cur_addr) * LP_RESOLUTION) + 32'(i_rd_correction);
    assign w_angle_sat = (w_sum > LP_MAXFOV) ? LP_MAXFOV_16 : w_sum[15:0];

    // ---------------- FSM state register ----------------
    always_ff @(posedge i_SYSTEM_clk or negedge i_SYSTEM_rst) begin
        if (!i_SYSTEM_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ---------------- FSM next state ----------------
    always_comb begin
        w_state_next = r_state;
        if (i_abort) begin
            w_state_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: if (w_start_ok) w_state_next = S_RD;
                S_RD:   w_state_next = S_CAP;
                S_CAP:  w_state_next = S_OUT;
                S_OUT:  if (w_xfer) w_state_next = w_at_last ? S_DONE : S_RD;
                S_DONE: w_state_next = S_IDLE;
                default: w_state_next = S_IDLE;
            endcase
        end
    end

    // ---------------- Datapath registers ----------------
    always_ff @(posedge i_SYSTEM_clk or negedge i_SYSTEM_rst) begin
        if (!i_SYSTEM_rst) begin
            r_cur_addr  <= '0;
            r_last_addr <= '0;
            r_angle     <= '0;
            r_addr      <= '0;
        end else begin
            if (r_state == S_IDLE && w_start_ok) begin
                r_cur_addr  <= i_first_addr;
                r_last_addr <= i_last_addr;
            end else if (r_state == S_CAP && !i_abort) begin
                // Correction arrives the cycle after the read strobe.
                r_angle <= w_angle_sat;
                r_addr  <= r_cur_addr;
            end else if (w_xfer && !w_at_last) begin
                // Natural N-bit overflow gives the 2**N-1 -> 0 wrap.
                r_cur_addr <= r_cur_addr + 1'b1;
            end
        end
    end

    // ---------------- Outputs ----------------
    assign o_rd_en     = (r_state == S_RD);
    assign o_rd_addr   = (r_state == S_RD) ? r_cur_addr : '0;
    assign o_valid     = (r_state == S_OUT);
    assign o_angle     = r_angle;
    assign o_addr      = r_addr;
    assign o_busy      = (r_state != S_IDLE);
    assign o_done      = (r_state == S_DONE);
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_memmu_sr_angle_reader.sv
module tb_memmu_sr_angle_reader;

    localparam int N = 14;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic         i_start = 1'b0;
    logic         i_abort = 1'b0;
    logic [N-1:0] i_first_addr = '0;
    logic [N-1:0] i_last_addr  = '0;
    logic         o_rd_en;
    logic [N-1:0] o_rd_addr;
    logic [3:0]   i_rd_correction = '0;
    logic         o_valid;
    logic         i_ready = 1'b0;
    logic [15:0]  o_angle;
    logic [N-1:0] o_addr;
    logic         o_busy;
    logic         o_done;
    logic [2:0]   o_dbg_state;

    memmu_sr_angle_reader #(.NUMBER_OF_ADDR_BITS(N), .FOV(360)) dut (
        .i_SYSTEM_clk   (clk),
        .i_SYSTEM_rst   (rst_n),
        .i_start        (i_start),
        .i_abort        (i_abort),
        .i_first_addr   (i_first_addr),
        .i_last_addr    (i_last_addr),
        .o_rd_en        (o_rd_en),
        .o_rd_addr      (o_rd_addr),
        .i_rd_correction(i_rd_correction),
        .o_valid        (o_valid),
        .i_ready        (i_ready),
        .o_angle        (o_angle),
        .o_addr         (o_addr),
        .o_busy         (o_busy),
        .o_done         (o_done),
        .o_dbg_state    (o_dbg_state)
    );

    // ---------------- memory model ----------------
    logic [3:0] mem [0:(2**N)-1];
    always @(posedge clk) begin
        if (o_rd_en) i_rd_correction <= mem[o_rd_addr];
    end

    // ---------------- bookkeeping ----------------
    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int done_cnt = 0;
    int done_exp = 0;
    int done_cyc = 0;
    int last_xfer_cyc = 0;
    logic [29:0]  exp_q[$];
    logic [N-1:0] rd_log[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- scoreboard / monitors ----------------
    always @(negedge clk) begin
        if (o_done) done_cnt++;
        if (o_rd_en) rd_log.push_back(o_rd_addr);
        if (rst_n && o_valid && i_ready && !i_abort) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_sample: got addr=%0d angle=%0d, expected no sample", o_addr, o_angle);
            end else begin
                logic [29:0] e;
                e = exp_q.pop_front();
                check("sample_addr", 32'(o_addr), 32'(e[29:16]));
                check("sample_angle", 32'(o_angle), 32'(e[15:0]));
            end
            last_xfer_cyc = cyc;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic start_scan(input logic [N-1:0] first, input logic [N-1:0] last);
        @(posedge clk); #1;
        i_first_addr = first;
        i_last_addr  = last;
        i_start      = 1'b1;
        @(posedge clk); #1;
        i_start      = 1'b0;
    endtask

    task automatic push_exp(input logic [N-1:0] a, input logic [15:0] ang);
        exp_q.push_back({a, ang});
    endtask

    task automatic wait_done(input string name);
        bit found = 0;
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            if (o_done) begin
                found = 1;
                break;
            end
        end
        check({name, "_done_seen"}, 32'(found), 32'd1);
        done_cyc = cyc;
        done_exp++;
        @(negedge clk); #1;
        check({name, "_busy_after"}, 32'(o_busy), 32'd0);
        check({name, "_done_count"}, 32'(done_cnt), 32'(done_exp));
        check({name, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic wait_rd(input logic [N-1:0] a, input string name);
        bit found = 0;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (o_rd_en && o_rd_addr == a) begin
                found = 1;
                break;
            end
        end
        check({name, "_rd_seen"}, 32'(found), 32'd1);
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_rd_en"},   32'(o_rd_en),   32'd0);
        check({name, "_rd_addr"}, 32'(o_rd_addr), 32'd0);
        check({name, "_valid"},   32'(o_valid),   32'd0);
        check({name, "_angle"},   32'(o_angle),   32'd0);
        check({name, "_addr"},    32'(o_addr),    32'd0);
        check({name, "_busy"},    32'(o_busy),    32'd0);
        check({name, "_done"},    32'(o_done),    32'd0);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [N-1:0] addr;
        logic [3:0]   corr;
        logic [15:0]  angle;
    } vec_t;
    vec_t vt[9];

    initial begin
        for (int i = 0; i < 2**N; i++) mem[i] = 4'd0;

        vt[0] = '{14'd12000, 4'd5,  16'd35999};
        vt[1] = '{14'd11999, 4'd2,  16'd35999};
        vt[2] = '{14'd11000, 4'd7,  16'd33007};
        vt[3] = '{14'd0,     4'd0,  16'd0};
        vt[4] = '{14'd16383, 4'd15, 16'd35999};
        vt[5] = '{14'd100,   4'd3,  16'd303};
        vt[6] = '{14'd11999, 4'd0,  16'd35997};
        vt[7] = '{14'd11999, 4'd1,  16'd35998};
        vt[8] = '{14'd11998, 4'd15, 16'd35999};

        // ---- reset state ----
        #12;
        check_all_zero("reset");
        @(posedge clk); #1;
        rst_n = 1'b1;

        // ---- basic scan with latency ----
        mem[0] = 4'd0; mem[1] = 4'd1; mem[2] = 4'd2; mem[3] = 4'd2;
        push_exp(14'd0, 16'd0);
        push_exp(14'd1, 16'd4);
        push_exp(14'd2, 16'd8);
        push_exp(14'd3, 16'd11);
        i_ready = 1'b1;
        rd_log.delete();
        start_scan(14'd0, 14'd3);
        @(negedge clk);
        check("basic_rd_en_k1", 32'(o_rd_en), 32'd1);
        check("basic_rd_addr_k1", 32'(o_rd_addr), 32'd0);
        check("basic_busy_k1", 32'(o_busy), 32'd1);
        @(negedge clk);
        check("basic_valid_k2", 32'(o_valid), 32'd0);
        check("basic_rd_en_k2", 32'(o_rd_en), 32'd0);
        @(negedge clk);
        check("basic_valid_k3", 32'(o_valid), 32'd1);
        wait_done("basic");
        check("basic_done_latency", 32'(done_cyc - last_xfer_cyc), 32'd1);
        check("basic_rd_count", 32'(rd_log.size()), 32'd4);

        // ---- table-driven single-sample scans (first == last) ----
        for (int i = 0; i < 9; i++) begin
            mem[vt[i].addr] = vt[i].corr;
            push_exp(vt[i].addr, vt[i].angle);
            start_scan(vt[i].addr, vt[i].addr);
            wait_done($sformatf("vec%0d", i));
        end

        // ---- wrap-around scan ----
        mem[16382] = 4'd4; mem[16383] = 4'd9; mem[0] = 4'd1; mem[1] = 4'd15;
        push_exp(14'd16382, 16'd35999);
        push_exp(14'd16383, 16'd35999);
        push_exp(14'd0,     16'd1);
        push_exp(14'd1,     16'd18);
        rd_log.delete();
        start_scan(14'd16382, 14'd1);
        wait_done("wrap");
        check("wrap_rd_count", 32'(rd_log.size()), 32'd4);
        if (rd_log.size() == 4) begin
            check("wrap_rd0", 32'(rd_log[0]), 32'd16382);
            check("wrap_rd1", 32'(rd_log[1]), 32'd16383);
            check("wrap_rd2", 32'(rd_log[2]), 32'd0);
            check("wrap_rd3", 32'(rd_log[3]), 32'd1);
        end

        // ---- backpressure ----
        mem[5] = 4'd2; mem[6] = 4'd3;
        push_exp(14'd5, 16'd17);
        push_exp(14'd6, 16'd21);
        i_ready = 1'b0;
        start_scan(14'd5, 14'd6);
        begin
            bit seen = 0;
            for (int n = 0; n < 20; n++) begin
                @(negedge clk);
                if (o_valid) begin
                    seen = 1;
                    break;
                end
            end
            check("bp_valid_seen", 32'(seen), 32'd1);
        end
        for (int c = 0; c < 5; c++) begin
            if (c > 0) @(negedge clk);
            check("bp_hold_valid", 32'(o_valid), 32'd1);
            check("bp_hold_angle", 32'(o_angle), 32'd17);
            check("bp_hold_addr",  32'(o_addr),  32'd5);
            check("bp_hold_rd_en", 32'(o_rd_en), 32'd0);
        end
        @(posedge clk); #1;
        i_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("bp_next_rd_en", 32'(o_rd_en), 32'd1);
        check("bp_next_rd_addr", 32'(o_rd_addr), 32'd6);
        check("bp_next_valid", 32'(o_valid), 32'd0);
        wait_done("bp");

        // ---- abort during third sample, start ignored mid-scan ----
        mem[0] = 4'd3; mem[1] = 4'd0; mem[2] = 4'd9;
        push_exp(14'd0, 16'd3);
        push_exp(14'd1, 16'd3);
        start_scan(14'd0, 14'd100);
        wait_rd(14'd1, "abort_a1");
        @(posedge clk); #1;
        i_first_addr = 14'd500;
        i_last_addr  = 14'd500;
        i_start      = 1'b1;
        @(posedge clk); #1;
        i_start      = 1'b0;
        wait_rd(14'd2, "abort_a2");
        @(posedge clk);
        @(posedge clk); #1;
        i_abort = 1'b1;
        @(negedge clk);
        check("abort_pending_valid", 32'(o_valid), 32'd1);
        @(posedge clk); #1;
        i_abort = 1'b0;
        check("abort_busy", 32'(o_busy), 32'd0);
        check("abort_valid", 32'(o_valid), 32'd0);
        check("abort_rd_en", 32'(o_rd_en), 32'd0);
        @(negedge clk); #1;
        check("abort_no_done", 32'(done_cnt), 32'(done_exp));
        check("abort_queue", 32'(exp_q.size()), 32'd0);
        check("abort_idle_rd_en", 32'(o_rd_en), 32'd0);

        // ---- start together with abort in IDLE ----
        @(posedge clk); #1;
        i_first_addr = 14'd7;
        i_last_addr  = 14'd7;
        i_start = 1'b1;
        i_abort = 1'b1;
        @(posedge clk); #1;
        i_start = 1'b0;
        i_abort = 1'b0;
        @(negedge clk);
        check("start_abort_busy", 32'(o_busy), 32'd0);
        check("start_abort_rd_en", 32'(o_rd_en), 32'd0);

        // ---- asynchronous reset mid-scan ----
        start_scan(14'd20, 14'd22);
        wait_rd(14'd20, "rst");
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("rst_mid");
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk); #1;
        check("rst_no_done", 32'(done_cnt), 32'(done_exp));
        mem[20] = 4'd1; mem[21] = 4'd2; mem[22] = 4'd3;
        push_exp(14'd20, 16'd61);
        push_exp(14'd21, 16'd65);
        push_exp(14'd22, 16'd69);
        start_scan(14'd20, 14'd22);
        wait_done("rst_clean");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // ---------------- global watchdog ----------------
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected test completion");
        $fatal(1, "watchdog expired");
    end

endmodule
